load_store_buffer: RTL and testbench

- In-order memory-operation queue between the instruction unit, the memory controller and the reorder buffer (ROB).
- Holds issued loads and stores and resolves their operands by snooping result broadcasts.
- Loads execute as soon as they reach the queue head with ready operands. Stores execute only when their ROB entry is the oldest in flight.
- Completion is reported to the ROB as (lsbUpdate, lsbRobIndex, lsbUpdateVal).

---
 rtl/load_store_buffer_pkg.sv | 24 ++
 rtl/load_extend.sv | 22 ++
 rtl/load_store_buffer_chk.sv | 21 ++
 rtl/load_store_buffer.sv | 238 +++++++++++++++++++++++
 tb/tb_load_store_buffer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_buffer_pkg.sv
// Shared encodings for the load/store buffer: memory access sizes, RV32I
// load/store funct3 codes and the issue-FSM states.
package load_store_buffer_pkg;

    localparam int LSB_WIDTH_DEF = 3;
    localparam int ROB_WIDTH_DEF = 4;

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } lsb_state_e;

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of low-aligned raw read data according to the load funct3.
module load_extend
    import load_store_buffer_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] rawData,
    output logic [31:0] extVal
);

    // Select extension by access size; bit 2 of funct3 marks the unsigned forms
    always_comb begin
        extVal = rawData;
        case (funct3)
            F3_B:    extVal = {{24{rawData[7]}}, rawData[7:0]};
            F3_H:    extVal = {{16{rawData[15]}}, rawData[15:0]};
            F3_BU:   extVal = {24'h000000, rawData[7:0]};
            F3_HU:   extVal = {16'h0000, rawData[15:0]};
            default: extVal = rawData;
        endcase
    end

endmodule

// File: rtl/load_store_buffer_chk.sv
// Simulation-only protocol checks for the load/store buffer.
module load_store_buffer_chk #(
    parameter int LSB_WIDTH = 3,
    parameter int LSB_SIZE  = 2**LSB_WIDTH
) (
    input logic             clockIn,
    input logic             resetIn,
    input logic             clear,
    input logic             addValid,
    input logic [LSB_WIDTH:0] count
);

    // The issue stage must never enqueue while every slot is occupied
    always @(posedge clockIn) begin
        if (!resetIn && !clear && addValid) begin
            assert (count != (LSB_WIDTH + 1)'(LSB_SIZE))
                else $error("load_store_buffer: enqueue while every slot is occupied");
        end
    end

endmodule

// File: rtl/load_store_buffer.sv
// In-order load/store queue: snoops operand broadcasts, issues the head entry to
// memory (stores only at ROB head) and reports completion back to the ROB.
module load_store_buffer
    import load_store_buffer_pkg::*;
#(
    parameter int LSB_WIDTH = LSB_WIDTH_DEF,
    parameter int LSB_SIZE  = 2**LSB_WIDTH,
    parameter int ROB_WIDTH = ROB_WIDTH_DEF
) (
    input  logic                 clockIn,
    input  logic                 resetIn,
    input  logic                 clear,
    input  logic                 addValid,
    input  logic                 addIsStore,
    input  logic [2:0]           addFunct3,
    input  logic                 addBaseReady,
    input  logic [31:0]          addBaseVal,
    input  logic [ROB_WIDTH-1:0] addBaseDep,
    input  logic                 addDataReady,
    input  logic [31:0]          addDataVal,
    input  logic [ROB_WIDTH-1:0] addDataDep,
    input  logic [31:0]          addOffset,
    input  logic [ROB_WIDTH-1:0] addRobIndex,
    output logic                 full,
    input  logic                 rsUpdate,
    input  logic [ROB_WIDTH-1:0] rsRobIndex,
    input  logic [31:0]          rsUpdateVal,
    input  logic [ROB_WIDTH-1:0] robBeginId,
    input  logic                 beginValid,
    output logic                 memRequest,
    output logic                 memWrite,
    output logic [31:0]          memAddr,
    output logic [31:0]          memData,
    output logic [1:0]           memSize,
    input  logic                 memDone,
    input  logic [31:0]          memReadData,
    output logic                 lsbUpdate,
    output logic [ROB_WIDTH-1:0] lsbRobIndex,
    output logic [31:0]          lsbUpdateVal
);

    localparam int CW = LSB_WIDTH + 1;
    localparam logic [LSB_WIDTH-1:0] PTR_ONE  = LSB_WIDTH'(1);
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]        CNT_SIZE = CW'(LSB_SIZE);
    localparam logic [CW-1:0]        CNT_FULL = CW'(LSB_SIZE - 1);

    logic [LSB_SIZE-1:0]  valid_r, is_store_r, base_rdy_r, data_rdy_r;
    logic [2:0]           funct3_r   [LSB_SIZE];
    logic [31:0]          base_val_r [LSB_SIZE];
    logic [31:0]          data_val_r [LSB_SIZE];
    logic [31:0]          offset_r   [LSB_SIZE];
    logic [ROB_WIDTH-1:0] base_dep_r [LSB_SIZE];
    logic [ROB_WIDTH-1:0] data_dep_r [LSB_SIZE];
    logic [ROB_WIDTH-1:0] rob_idx_r  [LSB_SIZE];

    logic [LSB_WIDTH-1:0] head_r, tail_r;
    logic [CW-1:0]        count_r, count_nxt_s;
    lsb_state_e           state_r;

    logic        push_s, pop_s, head_elig_s;
    logic [32:0] enq_base_s, enq_data_s;
    logic [31:0] ext_val_s;

    // Returns {ready, value} after applying both result broadcasts to one operand
    function automatic logic [32:0] resolve_op(
        input logic                 rdy,
        input logic [31:0]          val,
        input logic [ROB_WIDTH-1:0] dep,
        input logic                 rs_v,
        input logic [ROB_WIDTH-1:0] rs_i,
        input logic [31:0]          rs_d,
        input logic                 lsb_v,
        input logic [ROB_WIDTH-1:0] lsb_i,
        input logic [31:0]          lsb_d
    );
        logic [32:0] res;
        if (rdy) begin
            res = {1'b1, val};
        end else if (rs_v && (rs_i == dep)) begin
            res = {1'b1, rs_d};
        end else if (lsb_v && (lsb_i == dep)) begin
            res = {1'b1, lsb_d};
        end else begin
            res = {1'b0, val};
        end
        return res;
    endfunction

    load_extend u_ext (
        .funct3  (funct3_r[head_r]),
        .rawData (memReadData),
        .extVal  (ext_val_s)
    );

    load_store_buffer_chk #(.LSB_WIDTH(LSB_WIDTH), .LSB_SIZE(LSB_SIZE)) u_chk (
        .clockIn  (clockIn),
        .resetIn  (resetIn),
        .clear    (clear),
        .addValid (addValid),
        .count    (count_r)
    );

    // Head eligibility, queue push/pop and the operands of the arriving entry
    always_comb begin
        head_elig_s = 1'b0;
        if (valid_r[head_r] && base_rdy_r[head_r] && data_rdy_r[head_r]) begin
            if (is_store_r[head_r]) begin
                head_elig_s = beginValid && (robBeginId == rob_idx_r[head_r]);
            end else begin
                head_elig_s = 1'b1;
            end
        end else begin
            head_elig_s = 1'b0;
        end
        push_s = addValid && !clear && (count_r != CNT_SIZE);
        pop_s  = (state_r == ST_WAIT) && memDone && !clear;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
        enq_base_s = resolve_op(addBaseReady, addBaseVal, addBaseDep, rsUpdate, rsRobIndex,
                                rsUpdateVal, lsbUpdate, lsbRobIndex, lsbUpdateVal);
        enq_data_s = resolve_op(addDataReady, addDataVal, addDataDep, rsUpdate, rsRobIndex,
                                rsUpdateVal, lsbUpdate, lsbRobIndex, lsbUpdateVal);
    end

    // Queue storage, issue FSM and all registered outputs
    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            head_r       <= {LSB_WIDTH{1'b0}};
            tail_r       <= {LSB_WIDTH{1'b0}};
            count_r      <= {CW{1'b0}};
            valid_r      <= {LSB_SIZE{1'b0}};
            state_r      <= ST_IDLE;
            full         <= 1'b0;
            memRequest   <= 1'b0;
            memWrite     <= 1'b0;
            memAddr      <= 32'h0;
            memData      <= 32'h0;
            memSize      <= MEM_BYTE;
            lsbUpdate    <= 1'b0;
            lsbRobIndex  <= {ROB_WIDTH{1'b0}};
            lsbUpdateVal <= 32'h0;
        end else if (clear) begin
            head_r    <= {LSB_WIDTH{1'b0}};
            tail_r    <= {LSB_WIDTH{1'b0}};
            count_r   <= {CW{1'b0}};
            valid_r   <= {LSB_SIZE{1'b0}};
            full      <= 1'b0;
            lsbUpdate <= 1'b0;
            // A committed store already on the bus must still be seen through
            case (state_r)
                ST_WAIT: begin
                    if (memWrite && !memDone) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        state_r    <= ST_IDLE;
                        memRequest <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (memDone) begin
                        state_r    <= ST_IDLE;
                        memRequest <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    memRequest <= 1'b0;
                end
            endcase
        end else begin
            lsbUpdate <= 1'b0;
            full      <= (count_nxt_s >= CNT_FULL);
            count_r   <= count_nxt_s;
            for (int i = 0; i < LSB_SIZE; i++) begin
                if (valid_r[LSB_WIDTH'(i)]) begin
                    {base_rdy_r[LSB_WIDTH'(i)], base_val_r[LSB_WIDTH'(i)]} <= resolve_op(
                        base_rdy_r[LSB_WIDTH'(i)], base_val_r[LSB_WIDTH'(i)], base_dep_r[LSB_WIDTH'(i)],
                        rsUpdate, rsRobIndex, rsUpdateVal, lsbUpdate, lsbRobIndex, lsbUpdateVal);
                    {data_rdy_r[LSB_WIDTH'(i)], data_val_r[LSB_WIDTH'(i)]} <= resolve_op(
                        data_rdy_r[LSB_WIDTH'(i)], data_val_r[LSB_WIDTH'(i)], data_dep_r[LSB_WIDTH'(i)],
                        rsUpdate, rsRobIndex, rsUpdateVal, lsbUpdate, lsbRobIndex, lsbUpdateVal);
                end
            end
            case (state_r)
                ST_IDLE: begin
                    if (head_elig_s) begin
                        memRequest <= 1'b1;
                        memWrite   <= is_store_r[head_r];
                        memSize    <= funct3_r[head_r][1:0];
                        memData    <= data_val_r[head_r];
                        memAddr    <= base_val_r[head_r] + offset_r[head_r];
                        state_r    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (memDone) begin
                        memRequest       <= 1'b0;
                        valid_r[head_r]  <= 1'b0;
                        head_r           <= head_r + PTR_ONE;
                        lsbUpdate        <= 1'b1;
                        lsbRobIndex      <= rob_idx_r[head_r];
                        lsbUpdateVal     <= memWrite ? 32'h0 : ext_val_s;
                        state_r          <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (memDone) begin
                        memRequest <= 1'b0;
                        state_r    <= ST_IDLE;
                    end
                end
                default: begin
                    memRequest <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
            if (push_s) begin
                valid_r[tail_r]    <= 1'b1;
                is_store_r[tail_r] <= addIsStore;
                funct3_r[tail_r]   <= addFunct3;
                base_rdy_r[tail_r] <= enq_base_s[32];
                base_val_r[tail_r] <= enq_base_s[31:0];
                base_dep_r[tail_r] <= addBaseDep;
                data_rdy_r[tail_r] <= enq_data_s[32];
                data_val_r[tail_r] <= enq_data_s[31:0];
                data_dep_r[tail_r] <= addDataDep;
                offset_r[tail_r]   <= addOffset;
                rob_idx_r[tail_r]  <= addRobIndex;
                tail_r             <= tail_r + PTR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_load_store_buffer.sv
// Directed, table-driven bench for load_store_buffer with hand-computed expectations.
module tb_load_store_buffer;
    import load_store_buffer_pkg::*;

    logic        clockIn = 1'b0;
    logic        resetIn, clear, addValid, addIsStore, addBaseReady, addDataReady;
    logic [2:0]  addFunct3;
    logic [31:0] addBaseVal, addDataVal, addOffset, rsUpdateVal, memReadData;
    logic [3:0]  addBaseDep, addDataDep, addRobIndex, rsRobIndex, robBeginId;
    logic        rsUpdate, beginValid, memDone;
    logic        full, memRequest, memWrite, lsbUpdate;
    logic [31:0] memAddr, memData, lsbUpdateVal;
    logic [1:0]  memSize;
    logic [3:0]  lsbRobIndex;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] base;
        logic [31:0] off;
        logic [3:0]  rob;
        logic [31:0] rd;
        logic [31:0] exp_addr;
        logic [1:0]  exp_size;
        logic [31:0] exp_val;
    } vec_t;
    vec_t vecs[$];

    load_store_buffer dut (
        .clockIn(clockIn), .resetIn(resetIn), .clear(clear), .addValid(addValid),
        .addIsStore(addIsStore), .addFunct3(addFunct3), .addBaseReady(addBaseReady),
        .addBaseVal(addBaseVal), .addBaseDep(addBaseDep), .addDataReady(addDataReady),
        .addDataVal(addDataVal), .addDataDep(addDataDep), .addOffset(addOffset),
        .addRobIndex(addRobIndex), .full(full), .rsUpdate(rsUpdate), .rsRobIndex(rsRobIndex),
        .rsUpdateVal(rsUpdateVal), .robBeginId(robBeginId), .beginValid(beginValid),
        .memRequest(memRequest), .memWrite(memWrite), .memAddr(memAddr), .memData(memData),
        .memSize(memSize), .memDone(memDone), .memReadData(memReadData), .lsbUpdate(lsbUpdate),
        .lsbRobIndex(lsbRobIndex), .lsbUpdateVal(lsbUpdateVal)
    );

    always #5 clockIn = ~clockIn;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clockIn);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic enq(input logic st, input logic [2:0] f3, input logic brdy,
                       input logic [31:0] bval, input logic [3:0] bdep, input logic drdy,
                       input logic [31:0] dval, input logic [3:0] ddep,
                       input logic [31:0] off, input logic [3:0] rob);
        addValid = 1'b1; addIsStore = st; addFunct3 = f3;
        addBaseReady = brdy; addBaseVal = bval; addBaseDep = bdep;
        addDataReady = drdy; addDataVal = dval; addDataDep = ddep;
        addOffset = off; addRobIndex = rob;
        step();
        addValid = 1'b0;
    endtask

    task automatic wait_req(input string name, input int budget);
        int n;
        n = 0;
        while (memRequest !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check(name, {31'h0, memRequest}, 32'h1);
    endtask

    task automatic mem_done(input logic [31:0] rd);
        memDone = 1'b1; memReadData = rd;
        step();
        memDone = 1'b0;
    endtask

    initial begin
        resetIn = 1'b1; clear = 1'b0; addValid = 1'b0; addIsStore = 1'b0; addFunct3 = 3'd0;
        addBaseReady = 1'b0; addBaseVal = 32'h0; addBaseDep = 4'd0; addDataReady = 1'b0;
        addDataVal = 32'h0; addDataDep = 4'd0; addOffset = 32'h0; addRobIndex = 4'd0;
        rsUpdate = 1'b0; rsRobIndex = 4'd0; rsUpdateVal = 32'h0; robBeginId = 4'd0;
        beginValid = 1'b0; memDone = 1'b0; memReadData = 32'h0;

        vecs.push_back('{F3_W,  32'h0000_0100, 32'hFFFF_FFFC, 4'd3, 32'hDEAD_BEEF, 32'h0000_00FC, MEM_WORD, 32'hDEAD_BEEF});
        vecs.push_back('{F3_B,  32'h0000_2000, 32'h0000_0001, 4'd4, 32'h0000_0080, 32'h0000_2001, MEM_BYTE, 32'hFFFF_FF80});
        vecs.push_back('{F3_BU, 32'h0000_2000, 32'h0000_0002, 4'd5, 32'h0000_0080, 32'h0000_2002, MEM_BYTE, 32'h0000_0080});
        vecs.push_back('{F3_H,  32'h0000_0010, 32'h0000_0010, 4'd6, 32'h0000_8001, 32'h0000_0020, MEM_HALF, 32'hFFFF_8001});
        vecs.push_back('{F3_HU, 32'hFFFF_FFFF, 32'h0000_0001, 4'd7, 32'h1234_F00D, 32'h0000_0000, MEM_HALF, 32'h0000_F00D});
        vecs.push_back('{F3_B,  32'h0000_0300, 32'h0000_0000, 4'd8, 32'hAB12_347F, 32'h0000_0300, MEM_BYTE, 32'h0000_007F});

        step(); step();
        check("rst_memRequest", {31'h0, memRequest}, 32'h0);
        check("rst_memWrite", {31'h0, memWrite}, 32'h0);
        check("rst_lsbUpdate", {31'h0, lsbUpdate}, 32'h0);
        check("rst_full", {31'h0, full}, 32'h0);
        check("rst_memAddr", memAddr, 32'h0);
        check("rst_lsbUpdateVal", lsbUpdateVal, 32'h0);
        resetIn = 1'b0;
        step();

        // Table of ready loads: exact issue latency, address, size and extension
        for (int v = 0; v < vecs.size(); v++) begin
            enq(1'b0, vecs[v].f3, 1'b1, vecs[v].base, 4'd0, 1'b1, 32'h0, 4'd0, vecs[v].off, vecs[v].rob);
            check("ld_before_issue", {31'h0, memRequest}, 32'h0);
            step();
            check("ld_req", {31'h0, memRequest}, 32'h1);
            check("ld_addr", memAddr, vecs[v].exp_addr);
            check("ld_size", {30'h0, memSize}, {30'h0, vecs[v].exp_size});
            check("ld_write", {31'h0, memWrite}, 32'h0);
            mem_done(vecs[v].rd);
            check("ld_upd", {31'h0, lsbUpdate}, 32'h1);
            check("ld_rob", {28'h0, lsbRobIndex}, {28'h0, vecs[v].rob});
            check("ld_val", lsbUpdateVal, vecs[v].exp_val);
            check("ld_req_drop", {31'h0, memRequest}, 32'h0);
            step();
            check("ld_upd_pulse", {31'h0, lsbUpdate}, 32'h0);
        end

        // Store: waits for its data operand, then for the ROB head
        beginValid = 1'b1; robBeginId = 4'd2;
        enq(1'b1, F3_W, 1'b1, 32'h0000_0400, 4'd0, 1'b0, 32'h0, 4'd5, 32'h0000_0008, 4'd9);
        step(); step(); step();
        check("st_wait_data", {31'h0, memRequest}, 32'h0);
        rsUpdate = 1'b1; rsRobIndex = 4'd5; rsUpdateVal = 32'h0000_1234;
        step();
        rsUpdate = 1'b0;
        step(); step(); step();
        check("st_wait_rob", {31'h0, memRequest}, 32'h0);
        robBeginId = 4'd9;
        step();
        check("st_req", {31'h0, memRequest}, 32'h1);
        check("st_write", {31'h0, memWrite}, 32'h1);
        check("st_data", memData, 32'h0000_1234);
        check("st_addr", memAddr, 32'h0000_0408);
        check("st_size", {30'h0, memSize}, {30'h0, MEM_WORD});
        mem_done(32'hFFFF_FFFF);
        check("st_upd", {31'h0, lsbUpdate}, 32'h1);
        check("st_rob", {28'h0, lsbRobIndex}, 32'h9);
        check("st_val", lsbUpdateVal, 32'h0);
        beginValid = 1'b0; robBeginId = 4'd0;
        step();

        // Base captured from a broadcast in the enqueue cycle itself
        rsUpdate = 1'b1; rsRobIndex = 4'd15; rsUpdateVal = 32'h0000_7000;
        enq(1'b0, F3_W, 1'b0, 32'h0, 4'd15, 1'b1, 32'h0, 4'd0, 32'h0000_0010, 4'd1);
        rsUpdate = 1'b0;
        step();
        check("snoop_enq_req", {31'h0, memRequest}, 32'h1);
        check("snoop_enq_addr", memAddr, 32'h0000_7010);
        mem_done(32'h0000_0011);
        check("snoop_enq_val", lsbUpdateVal, 32'h0000_0011);
        step();

        // Fill to the full threshold, release all at once, drain in order (pointers wrap)
        for (int i = 0; i < 7; i++) begin
            if (i == 6) check("full_below", {31'h0, full}, 32'h0);
            enq(1'b0, F3_W, 1'b0, 32'h0, 4'd12, 1'b1, 32'h0, 4'd0, 32'(4 * i), 4'(i + 1));
        end
        check("full_set", {31'h0, full}, 32'h1);
        check("full_no_issue", {31'h0, memRequest}, 32'h0);
        rsUpdate = 1'b1; rsRobIndex = 4'd12; rsUpdateVal = 32'h0000_1000;
        step();
        rsUpdate = 1'b0;
        for (int i = 0; i < 7; i++) begin
            wait_req("drain_req", 4);
            check("drain_addr", memAddr, 32'h0000_1000 + 32'(4 * i));
            mem_done(32'(i));
            check("drain_rob", {28'h0, lsbRobIndex}, 32'(i + 1));
            check("drain_val", lsbUpdateVal, 32'(i));
            if (i == 0) check("full_drop", {31'h0, full}, 32'h0);
        end
        step();

        // clear while a load waits: aborted, no update, queued entries flushed
        enq(1'b0, F3_W, 1'b1, 32'h0000_0500, 4'd0, 1'b1, 32'h0, 4'd0, 32'h0, 4'd10);
        enq(1'b0, F3_W, 1'b0, 32'h0, 4'd13, 1'b1, 32'h0, 4'd0, 32'h0, 4'd11);
        check("clr_ld_req", {31'h0, memRequest}, 32'h1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_ld_drop", {31'h0, memRequest}, 32'h0);
        rsUpdate = 1'b1; rsRobIndex = 4'd13; rsUpdateVal = 32'h0000_0800;
        mem_done(32'h0000_0BAD);
        rsUpdate = 1'b0;
        check("clr_ld_noupd", {31'h0, lsbUpdate}, 32'h0);
        step(); step();
        check("clr_ld_flushed", {31'h0, memRequest}, 32'h0);
        enq(1'b0, F3_W, 1'b1, 32'h0000_0050, 4'd0, 1'b1, 32'h0, 4'd0, 32'h0, 4'd12);
        step();
        check("clr_after_addr", memAddr, 32'h0000_0050);
        mem_done(32'h0000_0099);
        check("clr_after_rob", {28'h0, lsbRobIndex}, 32'hC);
        check("clr_after_val", lsbUpdateVal, 32'h0000_0099);
        step();

        // clear while a store waits: request held until memDone, no update
        beginValid = 1'b1; robBeginId = 4'd14;
        enq(1'b1, F3_W, 1'b1, 32'h0000_0600, 4'd0, 1'b1, 32'h0000_CAFE, 4'd0, 32'h0, 4'd14);
        wait_req("drain_st_req", 4);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("drain_hold1", {31'h0, memRequest}, 32'h1);
        step(); step();
        check("drain_hold2", {31'h0, memRequest}, 32'h1);
        mem_done(32'h0);
        check("drain_done", {31'h0, memRequest}, 32'h0);
        check("drain_noupd", {31'h0, lsbUpdate}, 32'h0);
        step();
        check("drain_noupd2", {31'h0, lsbUpdate}, 32'h0);
        beginValid = 1'b0; robBeginId = 4'd0;

        // Reset in the middle of a transaction with the queue at the full threshold
        enq(1'b0, F3_W, 1'b1, 32'h0000_0040, 4'd0, 1'b1, 32'h0, 4'd0, 32'h0, 4'd2);
        for (int i = 0; i < 6; i++) begin
            enq(1'b0, F3_W, 1'b0, 32'h0, 4'd9, 1'b1, 32'h0, 4'd0, 32'h0, 4'd4);
        end
        check("rstw_full", {31'h0, full}, 32'h1);
        check("rstw_req", {31'h0, memRequest}, 32'h1);
        resetIn = 1'b1;
        step();
        resetIn = 1'b0;
        check("rstw_req_drop", {31'h0, memRequest}, 32'h0);
        check("rstw_full_drop", {31'h0, full}, 32'h0);
        enq(1'b0, F3_W, 1'b1, 32'h0000_0040, 4'd0, 1'b1, 32'h0, 4'd0, 32'h0000_0004, 4'd3);
        step();
        check("rstw_after_req", {31'h0, memRequest}, 32'h1);
        check("rstw_after_addr", memAddr, 32'h0000_0044);
        mem_done(32'h0000_0055);
        check("rstw_after_rob", {28'h0, lsbRobIndex}, 32'h3);
        check("rstw_after_val", lsbUpdateVal, 32'h0000_0055);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
